ncpu32k_ifu_seq: RTL and testbench

//  Fetch sequencer: owns the fetch PC and issues one-outstanding I-cache requests.

---
 rtl/ncpu32k_ifu_seq.sv | 95 +++++++++
 tb/tb_ncpu32k_ifu_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ncpu32k_ifu_seq.sv
// ncpu32k_ifu_seq: fetch PC sequencer with one outstanding I-cache request and a 1-entry insn buffer
module ncpu32k_ifu_seq #(
  parameter int AW = 32,
  parameter int IW = 32,
  parameter logic [AW-1:0] RST_VECTOR = 32'h80000000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ic_req_vld,
  input  logic          ic_req_rdy,
  output logic [AW-3:0] ic_req_pc,
  input  logic          ic_rsp_vld,
  input  logic [IW-1:0] ic_rsp_insn,
  input  logic          ic_rsp_EITM,
  input  logic          ic_rsp_EIPF,
  output logic          pidu_insn_vld,
  output logic [IW-1:0] pidu_insn,
  output logic [AW-3:0] pidu_pc,
  output logic          pidu_EITM,
  output logic          pidu_EIPF,
  input  logic          pidu_rdy,
  input  logic          jmprel,
  input  logic [AW-3:0] jmprel_tgt,
  input  logic          flush_vld,
  input  logic [AW-3:0] flush_tgt
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, DROP = 3'd3, HALT = 3'd4;
  logic [2:0] state;
  logic [AW-3:0] fetch_pc, pending_pc, next_pc;
  logic out_acc, redir_jr, redir, buf_free, hs, load;
  always_comb begin
    out_acc = pidu_insn_vld & pidu_rdy;
    redir_jr = out_acc & jmprel;
    redir = flush_vld | redir_jr;
    next_pc = flush_vld ? flush_tgt : redir_jr ? jmprel_tgt : fetch_pc;
    buf_free = ~pidu_insn_vld | out_acc;
    ic_req_vld = (state == REQ) & buf_free;
    ic_req_pc = next_pc;
    hs = ic_req_vld & ic_req_rdy;
    load = (state == WAIT) & ic_rsp_vld & ~redir;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RST_VECTOR[AW-1:2];
      pending_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          fetch_pc <= next_pc;
          state <= REQ;
        end
        REQ: begin
          fetch_pc <= hs ? next_pc + 1'b1 : next_pc;
          if (hs) pending_pc <= next_pc;
          if (hs) state <= WAIT;
        end
        WAIT: begin
          fetch_pc <= next_pc;
          state <= ~ic_rsp_vld ? (redir ? DROP : WAIT) :
                   (~redir & (ic_rsp_EITM | ic_rsp_EIPF)) ? HALT : REQ;
        end
        DROP: begin
          fetch_pc <= next_pc;
          if (ic_rsp_vld) state <= REQ;
        end
        HALT: begin
          // The faulting insn is the last one fetched until the backend redirects
          if (flush_vld) fetch_pc <= flush_tgt;
          if (flush_vld) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pidu_insn_vld <= 1'b0;
      pidu_insn <= '0;
      pidu_pc <= '0;
      pidu_EITM <= 1'b0;
      pidu_EIPF <= 1'b0;
    end else if (flush_vld) begin
      pidu_insn_vld <= 1'b0;
    end else if (load) begin
      pidu_insn_vld <= 1'b1;
      pidu_insn <= ic_rsp_insn;
      pidu_pc <= pending_pc;
      pidu_EITM <= ic_rsp_EITM;
      pidu_EIPF <= ic_rsp_EIPF;
    end else if (out_acc) begin
      pidu_insn_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ncpu32k_ifu_seq.sv
// tb_ncpu32k_ifu_seq: random fetch traffic against a transaction-level fetch-stream model
module tb_ncpu32k_ifu_seq;
  logic clk = 0, rst = 1;
  logic ic_req_vld, ic_req_rdy = 0, ic_rsp_vld = 0, ic_rsp_EITM = 0, ic_rsp_EIPF = 0;
  logic [29:0] ic_req_pc, pidu_pc, jmprel_tgt = '0, flush_tgt = '0;
  logic [31:0] ic_rsp_insn = '0, pidu_insn;
  logic pidu_insn_vld, pidu_EITM, pidu_EIPF, pidu_rdy = 0, jmprel = 0, flush_vld = 0;
  ncpu32k_ifu_seq dut (
    .clk(clk), .rst(rst),
    .ic_req_vld(ic_req_vld), .ic_req_rdy(ic_req_rdy), .ic_req_pc(ic_req_pc),
    .ic_rsp_vld(ic_rsp_vld), .ic_rsp_insn(ic_rsp_insn), .ic_rsp_EITM(ic_rsp_EITM), .ic_rsp_EIPF(ic_rsp_EIPF),
    .pidu_insn_vld(pidu_insn_vld), .pidu_insn(pidu_insn), .pidu_pc(pidu_pc),
    .pidu_EITM(pidu_EITM), .pidu_EIPF(pidu_EIPF), .pidu_rdy(pidu_rdy),
    .jmprel(jmprel), .jmprel_tgt(jmprel_tgt), .flush_vld(flush_vld), .flush_tgt(flush_tgt)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  int p_flush, p_jmp, p_prdy, p_crdy, p_itm, p_ipf, lat, req_seen;
  bit f_flush, f_jmp, bvld, halted, idle, b_itm, b_ipf, last_req;
  logic [29:0] f_tgt, f_jtgt, exp_pc, b_pc;
  logic [31:0] b_insn;
  logic [63:0] snap;
  logic [29:0] oq_pc[$], reqlog[$];
  bit oq_stale[$];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction
  task automatic do_reset();
    rst = 1; flush_vld = 0; jmprel = 0; pidu_rdy = 1; ic_req_rdy = 1;
    ic_rsp_vld = 1; ic_rsp_insn = $urandom; ic_rsp_EITM = 0; ic_rsp_EIPF = 0;
    @(posedge clk); #1 ic_rsp_vld = 0;
    @(posedge clk); #1;
    chk("rst_vld", {pidu_insn_vld, ic_req_vld}, 0);
    chk("rst_pidu", {pidu_insn, pidu_pc, pidu_EITM, pidu_EIPF}, 0);
    rst = 0; exp_pc = 30'h20000000; halted = 0; bvld = 0; idle = 1; lat = 0;
    oq_pc.delete(); oq_stale.delete();
  endtask
  task automatic step();
    bit rsp, oacc, redir, exp_req, st, ld;
    logic [29:0] nxt, rpc;
    flush_vld = f_flush | pct(p_flush);
    flush_tgt = f_flush ? f_tgt : pct(20) ? 30'h3FFFFFFF : 30'($urandom);
    jmprel = f_jmp | pct(p_jmp);
    jmprel_tgt = f_jmp ? f_jtgt : 30'($urandom);
    pidu_rdy = f_jmp | pct(p_prdy);
    ic_req_rdy = pct(p_crdy);
    rsp = 0;
    if (oq_pc.size() > 0) begin
      if (lat == 0) rsp = 1;
      else lat--;
    end
    ic_rsp_vld = rsp; ic_rsp_insn = $urandom;
    ic_rsp_EITM = pct(p_itm); ic_rsp_EIPF = pct(p_ipf);
    #2;
    oacc = bvld && pidu_rdy;
    redir = oacc && jmprel && !halted;
    nxt = flush_vld ? flush_tgt : redir ? jmprel_tgt : exp_pc;
    exp_req = !halted && oq_pc.size() == 0 && (!bvld || oacc) && !idle;
    last_req = ic_req_vld;
    req_seen += int'(ic_req_vld);
    chk("req_vld", ic_req_vld, exp_req);
    if (exp_req) chk("req_pc", ic_req_pc, nxt);
    chk("pidu_vld", pidu_insn_vld, bvld);
    if (bvld) chk("pidu", {pidu_insn, pidu_pc, pidu_EITM, pidu_EIPF}, {b_insn, b_pc, b_itm, b_ipf});
    if (flush_vld || redir) foreach (oq_stale[i]) oq_stale[i] = 1;
    ld = 0; rpc = '0;
    if (rsp) begin
      st = oq_stale.pop_front();
      rpc = oq_pc.pop_front();
      ld = !st && !flush_vld && !redir;
    end
    if (flush_vld) begin
      bvld = 0; halted = 0;
    end else if (ld) begin
      bvld = 1; b_insn = ic_rsp_insn; b_pc = rpc; b_itm = ic_rsp_EITM; b_ipf = ic_rsp_EIPF;
      halted = ic_rsp_EITM | ic_rsp_EIPF;
    end else if (oacc) bvld = 0;
    exp_pc = nxt;
    if (exp_req && ic_req_rdy) begin
      reqlog.push_back(ic_req_pc);
      exp_pc = nxt + 30'd1;
      oq_pc.push_back(nxt); oq_stale.push_back(0);
      lat = $urandom_range(0, 2);
    end
    idle = 0; f_flush = 0; f_jmp = 0;
    @(posedge clk); #1;
  endtask
  task automatic wait_reqs(int n);
    for (int i = 0; i < 200 && reqlog.size() < n; i++) step();
    chk("req_cnt", reqlog.size(), n);
  endtask
  task automatic wait_buf();
    for (int i = 0; i < 200 && !pidu_insn_vld; i++) step();
    chk("buf_fill", pidu_insn_vld, 1);
  endtask
  initial begin
    p_flush = 0; p_jmp = 0; p_prdy = 100; p_crdy = 100; p_itm = 0; p_ipf = 0;
    f_flush = 0; f_jmp = 0; req_seen = 0;
    do_reset();
    reqlog.delete();
    wait_reqs(3);
    for (int i = 0; i < 3 && i < reqlog.size(); i++) chk("seq_pc", reqlog[i], 30'h20000000 + 30'(i));
    reqlog.delete(); f_flush = 1; f_tgt = 30'h3FFFFFFF;
    wait_reqs(2);
    if (reqlog.size() == 2) chk("wrap", {reqlog[0], reqlog[1]}, {30'h3FFFFFFF, 30'h0});
    p_prdy = 0; f_flush = 1; f_tgt = 30'h40;
    wait_buf();
    chk("jr_buf_pc", pidu_pc, 30'h40);
    reqlog.delete(); f_jmp = 1; f_jtgt = 30'h100;
    wait_reqs(1);
    if (reqlog.size() == 1) chk("jr_tgt", reqlog[0], 30'h100);
    p_prdy = 100;
    for (int i = 0; i < 200 && !(oq_pc.size() > 0 && lat == 0); i++) step();
    reqlog.delete(); f_flush = 1; f_tgt = 30'h200;
    step();
    chk("flush_drop", pidu_insn_vld, 0);
    wait_reqs(1);
    if (reqlog.size() == 1) chk("flush_tgt", reqlog[0], 30'h200);
    p_ipf = 100;
    for (int i = 0; i < 200 && !(pidu_insn_vld && pidu_EIPF); i++) step();
    chk("eipf", {pidu_insn_vld, pidu_EIPF}, 2'b11);
    p_ipf = 0; p_jmp = 50; p_prdy = 60; req_seen = 0;
    repeat (20) step();
    chk("halt_quiet", req_seen, 0);
    p_jmp = 0; p_prdy = 100; reqlog.delete(); f_flush = 1; f_tgt = 30'h10;
    wait_reqs(1);
    if (reqlog.size() == 1) chk("halt_resume", reqlog[0], 30'h10);
    p_prdy = 0;
    wait_buf();
    snap = {pidu_insn, pidu_pc, pidu_EITM, pidu_EIPF};
    repeat (5) begin
      step();
      chk("hold", {pidu_insn, pidu_pc, pidu_EITM, pidu_EIPF}, snap);
      chk("stall_req", ic_req_vld, 0);
    end
    p_prdy = 100;
    step();
    chk("resume_req", last_req, 1);
    p_flush = 4; p_jmp = 30; p_prdy = 70; p_crdy = 70; p_itm = 4; p_ipf = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
